// File: rtl/aes128_encrypt_core_pkg.sv
// Shared AES-128 types, constants and byte/state transforms.
package aes128_encrypt_core_pkg;

  localparam int unsigned NR = 10;
  localparam int unsigned NB = 4;

  // AES state: [column][row] of bytes, byte 0 (col 0, row 0) sits in [127:120].
  typedef logic [0:NB-1][0:3][7:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE,
    KEYLOAD,
    ROUND,
    DONE
  } fsm_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_state_t sub_bytes(input aes_state_t s);
    aes_state_t o;
    for (int unsigned c = 0; c < NB; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[c][r] = sbox(s[c][r]);
    return o;
  endfunction

  // Row r rotates left by r columns.
  function automatic aes_state_t shift_rows(input aes_state_t s);
    aes_state_t o;
    for (int unsigned c = 0; c < NB; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[c][r] = s[(c + r) % NB][r];
    return o;
  endfunction

  // Each output byte is 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3] over GF(2^8).
  function automatic aes_state_t mix_columns(input aes_state_t s);
    aes_state_t o;
    for (int unsigned c = 0; c < NB; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[c][r] = xtime(s[c][r]) ^ xtime(s[c][(r + 1) % 4]) ^ s[c][(r + 1) % 4]
                ^ s[c][(r + 2) % 4] ^ s[c][(r + 3) % 4];
    return o;
  endfunction

endpackage

// File: rtl/aes128_encrypt_core_if.sv
// Plaintext/key request and ciphertext response handshakes of the core.
interface aes128_encrypt_core_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_text;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_text;

  modport master (
    output in_valid, in_text, in_key, out_ready,
    input  in_ready, out_valid, out_text
  );

  modport slave (
    input  in_valid, in_text, in_key, out_ready,
    output in_ready, out_valid, out_text
  );
endinterface

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round
  import aes128_encrypt_core_pkg::*;
(
  input  aes_state_t   state,
  input  logic [127:0] round_key,
  input  logic         final_flag,
  output aes_state_t   next_state
);

  aes_state_t shifted;

  // The last round skips MixColumns.
  always_comb begin
    shifted    = shift_rows(sub_bytes(state));
    next_state = (final_flag ? shifted : mix_columns(shifted)) ^ round_key;
  end

endmodule

// File: rtl/key_schedule.sv
// On-the-fly AES-128 key expansion; round key r is presented while cnt==r+1.
module key_schedule
  import aes128_encrypt_core_pkg::*;
(
  input  logic         clk,
  input  logic         nrst,
  input  logic [3:0]   cnt,
  input  logic [127:0] key,
  output logic [127:0] round_key
);

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Load the cipher key at cnt 0, derive the next round key for cnt 1..10, then hold.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      round_key <= '0;
    end else if (cnt == 4'd0) begin
      round_key <= key;
    end else if (cnt <= 4'(NR)) begin
      round_key <= expand(round_key, rcon(cnt));
    end
  end

endmodule

// File: rtl/aes128_encrypt_core.sv
// Iterative AES-128 encryption core: one round per clock, fed by key_schedule.
module aes128_encrypt_core
  import aes128_encrypt_core_pkg::*;
#(
  parameter int unsigned NR = 10
) (
  input  logic                 clk,
  input  logic                 nrst,
  aes128_encrypt_core_if.slave bus
);

  if (NR != aes128_encrypt_core_pkg::NR) begin : g_nr_check
    $fatal(1, "aes128_encrypt_core: NR must be 10");
  end

  localparam logic [3:0] CNT_LAST = 4'(NR + 1);

  fsm_t         fsm;
  fsm_t         fsm_next;
  logic [3:0]   cnt;
  logic [127:0] text_reg;
  logic [127:0] key_reg;
  logic [127:0] round_key;
  logic [127:0] result;
  aes_state_t   state;
  aes_state_t   round_out;
  logic         final_flag;

  assign final_flag   = (fsm == ROUND) && (cnt == CNT_LAST);
  assign bus.out_text = result;

  key_schedule u_key_schedule (
    .clk       (clk),
    .nrst      (nrst),
    .cnt       (cnt),
    .key       (key_reg),
    .round_key (round_key)
  );

  aes_round u_round (
    .state      (state),
    .round_key  (round_key),
    .final_flag (final_flag),
    .next_state (round_out)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) fsm <= IDLE;
    else       fsm <= fsm_next;
  end

  // Next-state and handshake outputs; ready/valid follow the state directly.
  always_comb begin
    fsm_next      = fsm;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (fsm)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) fsm_next = KEYLOAD;
      end
      KEYLOAD: fsm_next = ROUND;
      ROUND:   if (cnt == CNT_LAST) fsm_next = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) fsm_next = IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

  // Capture request, step the round counter and the cipher state, latch the result.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt      <= '0;
      text_reg <= '0;
      key_reg  <= '0;
      state    <= '0;
      result   <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (bus.in_valid) begin
            text_reg <= bus.in_text;
            key_reg  <= bus.in_key;
            cnt      <= '0;
          end
        end
        KEYLOAD: cnt <= 4'd1;
        ROUND: begin
          if (cnt == 4'd1)   state <= text_reg ^ round_key;
          else if (!final_flag) state <= round_out;
          if (final_flag) result <= round_out;
          else            cnt    <= cnt + 4'd1;
        end
        DONE: if (bus.out_ready) cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Self-checking bench for aes128_encrypt_core against a behavioural AES-128 model.
module tb_aes128_encrypt_core;

  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_R0  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam int           LAT   = 12;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] sb [256];

  aes128_encrypt_core_if bus ();

  aes128_encrypt_core #(.NR(10)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, v, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv; v = inv;
      for (int k = 0; k < 4; k++) begin
        v = {v[6:0], v[7]};
        s = s ^ v;
      end
      sb[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]] ^ rc, sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c+r] = sb[s[4*((c+r)%4)+r]];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            s[4*c+r] = gmul(t[4*c+r], 8'h02) ^ gmul(t[4*c+(r+1)%4], 8'h03)
                     ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
      end else begin
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd+i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offer a request once in_ready is seen; returns at the negedge after the accepting edge.
  task automatic send(input logic [127:0] t, input logic [127:0] k);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_send", 128'(bus.in_ready), 128'd1);
    bus.in_valid = 1'b1;
    bus.in_text  = t;
    bus.in_key   = k;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_text  = rand128();
    bus.in_key   = rand128();
  endtask

  // lat counts clock edges after the accepting edge.
  task automatic wait_result(input int start, output logic [127:0] got, output int lat);
    lat = start;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    got = bus.out_text;
  endtask

  initial begin
    logic [127:0] got, pt, key, exp;
    int lat, hits;

    bus.in_valid  = 1'b0;
    bus.in_text   = '0;
    bus.in_key    = '0;
    bus.out_ready = 1'b0;
    build_sbox();

    repeat (2) @(negedge clk);
    check("reset_in_ready", 128'(bus.in_ready), 128'd1);
    check("reset_out_valid", 128'(bus.out_valid), 128'd0);
    check("reset_out_text", bus.out_text, '0);
    nrst = 1'b1;
    @(negedge clk);

    // App. B with a busy-time request (App. C.1) that must be ignored, then backpressure.
    send(B_PT, B_KEY);
    @(negedge clk);
    @(negedge clk);
    check("b_round0_state", dut.state, B_R0);
    check("busy_in_ready", 128'(bus.in_ready), 128'd0);
    bus.in_valid = 1'b1;
    bus.in_text  = C_PT;
    bus.in_key   = C_KEY;
    @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_result(4, got, lat);
    check("b_latency", 128'(lat), 128'(LAT));
    check("b_ciphertext", got, B_CT);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_out_valid", 128'(bus.out_valid), 128'd1);
      check("bp_out_text", bus.out_text, B_CT);
      check("bp_in_ready", 128'(bus.in_ready), 128'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("drain_out_valid", 128'(bus.out_valid), 128'd0);
    check("drain_in_ready", 128'(bus.in_ready), 128'd1);

    // App. C.1 with the consumer always ready.
    send(C_PT, C_KEY);
    wait_result(0, got, lat);
    check("c_latency", 128'(lat), 128'(LAT));
    check("c_ciphertext", got, C_CT);
    @(negedge clk);
    check("c_single_transfer", 128'(bus.out_valid), 128'd0);

    // Asynchronous reset partway through a computation.
    send(B_PT, B_KEY);
    repeat (5) @(negedge clk);
    nrst = 1'b0;
    #1;
    check("midrst_in_ready", 128'(bus.in_ready), 128'd1);
    check("midrst_out_valid", 128'(bus.out_valid), 128'd0);
    check("midrst_out_text", bus.out_text, '0);
    @(negedge clk);
    nrst = 1'b1;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) hits++;
    end
    check("midrst_no_pulse", 128'(hits), 128'd0);
    send(B_PT, B_KEY);
    wait_result(0, got, lat);
    check("post_rst_latency", 128'(lat), 128'(LAT));
    check("post_rst_ciphertext", got, B_CT);
    @(negedge clk);

    // Back-to-back random requests with out_ready tied high.
    for (int i = 0; i < 2; i++) begin
      pt  = rand128();
      key = rand128();
      exp = ref_encrypt(pt, key);
      send(pt, key);
      wait_result(0, got, lat);
      check("b2b_latency", 128'(lat), 128'(LAT));
      check("b2b_ciphertext", got, exp);
    end
    @(negedge clk);

    // Random requests with random consumer stall.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pt  = rand128();
      key = rand128();
      exp = ref_encrypt(pt, key);
      send(pt, key);
      wait_result(0, got, lat);
      check("rnd_latency", 128'(lat), 128'(LAT));
      check("rnd_ciphertext", got, exp);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check("rnd_hold_text", bus.out_text, exp);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("rnd_drain", 128'(bus.out_valid), 128'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
